// File: rtl/csd_scan_ctrl_if.sv
// Handshake and strobe bundle between the CSD scan sequencer and its
// digit-position datapath / host.
interface csd_scan_ctrl_if;
   logic       go;
   logic       hostWe;
   logic       Zi;
   logic       Zcsd;
   logic       Zcnt;
   logic       start;
   logic       weCsd;
   logic       reCsd;
   logic       weK;
   logic       reK;
   logic       Load;
   logic       enable;
   logic       loadCnt;
   logic       enCnt;
   logic       busy;
   logic       done;
   logic [2:0] found;

   modport master (
      input  go, hostWe, Zi, Zcsd, Zcnt,
      output start, weCsd, reCsd, weK, reK, Load, enable,
             loadCnt, enCnt, busy, done, found
   );

   modport slave (
      output go, hostWe, Zi, Zcsd, Zcnt,
      input  start, weCsd, reCsd, weK, reK, Load, enable,
             loadCnt, enCnt, busy, done, found
   );
endinterface

// File: rtl/csd_scan_ctrl.sv
// Sequencer that scans the 16-entry CSD memory for 8'h01 digits, logs up to
// four hit addresses into K memory, then replays K slots 0..3 into regK0..3.
module csd_scan_ctrl (
   input  logic            clk,
   input  logic            reset,
   csd_scan_ctrl_if.master bus
);

   typedef enum logic [3:0] {
      IDLE = 4'd0,
      INIT = 4'd1,
      RD   = 4'd2,
      CHK  = 4'd3,
      WRK  = 4'd4,
      ADV  = 4'd5,
      KCLR = 4'd6,
      KRD  = 4'd7,
      DONE = 4'd8
   } scanState_t;

   scanState_t state_r;
   scanState_t nextState_s;
   logic [2:0] hitCnt_r;
   logic [2:0] hitNext_s;
   logic [2:0] found_r;
   logic [2:0] foundD_s;
   logic       start_r,   startD_s;
   logic       weCsd_r,   weCsdD_s;
   logic       reCsd_r,   reCsdD_s;
   logic       weK_r,     weKD_s;
   logic       reK_r,     reKD_s;
   logic       load_r,    loadD_s;
   logic       loadCnt_r, loadCntD_s;
   logic       busy_r,    busyD_s;
   logic       done_r,    doneD_s;
   logic       enCnt_s;
   logic       enable_s;

   // Next-state selection and hit counter update
   always_comb begin
      nextState_s = state_r;
      hitNext_s   = hitCnt_r;
      case (state_r)
         IDLE: begin
            if (bus.go) begin
               nextState_s = INIT;
            end else begin
               nextState_s = IDLE;
            end
         end
         INIT: begin
            hitNext_s   = 3'd0;
            nextState_s = RD;
         end
         RD: begin
            nextState_s = CHK;
         end
         CHK: begin
            if (bus.Zcsd) begin
               nextState_s = WRK;
               // Saturate defensively; the WRK exit on Zcnt already caps it at 4
               if (hitCnt_r < 3'd4) begin
                  hitNext_s = hitCnt_r + 3'd1;
               end else begin
                  hitNext_s = hitCnt_r;
               end
            end else begin
               nextState_s = ADV;
            end
         end
         WRK: begin
            if (bus.Zcnt) begin
               nextState_s = KCLR;
            end else begin
               nextState_s = ADV;
            end
         end
         ADV: begin
            if (bus.Zi) begin
               nextState_s = RD;
            end else begin
               nextState_s = KCLR;
            end
         end
         KCLR: begin
            nextState_s = KRD;
         end
         KRD: begin
            if (bus.Zcnt) begin
               nextState_s = DONE;
            end else begin
               nextState_s = KRD;
            end
         end
         DONE: begin
            nextState_s = IDLE;
         end
         default: begin
            nextState_s = IDLE;
            hitNext_s   = 3'd0;
         end
      endcase
   end

   // Moore output values for the state being entered, registered below
   always_comb begin
      startD_s   = 1'b0;
      weCsdD_s   = 1'b0;
      reCsdD_s   = 1'b0;
      weKD_s     = 1'b0;
      reKD_s     = 1'b0;
      loadD_s    = 1'b0;
      loadCntD_s = 1'b0;
      doneD_s    = 1'b0;
      busyD_s    = 1'b1;
      case (nextState_s)
         IDLE: begin
            busyD_s  = 1'b0;
            weCsdD_s = bus.hostWe;
         end
         INIT: begin
            loadD_s    = 1'b1;
            loadCntD_s = 1'b1;
         end
         RD: begin
            startD_s = 1'b1;
            reCsdD_s = 1'b1;
         end
         CHK: begin
            startD_s = 1'b1;
         end
         WRK: begin
            startD_s = 1'b1;
            weKD_s   = 1'b1;
         end
         ADV: begin
            startD_s = 1'b1;
         end
         KCLR: begin
            loadCntD_s = 1'b1;
            reKD_s     = 1'b1;
         end
         KRD: begin
            reKD_s = 1'b1;
         end
         DONE: begin
            doneD_s = 1'b1;
         end
         default: begin
            busyD_s = 1'b0;
         end
      endcase
      if (nextState_s == KCLR) begin
         foundD_s = hitNext_s;
      end else begin
         foundD_s = found_r;
      end
   end

   // Counter strobes that must follow this cycle's datapath flags
   always_comb begin
      enCnt_s  = 1'b0;
      enable_s = 1'b0;
      case (state_r)
         CHK:     enCnt_s  = bus.Zcsd;
         ADV:     enable_s = bus.Zi;
         KRD:     enCnt_s  = ~bus.Zcnt;
         default: begin
            enCnt_s  = 1'b0;
            enable_s = 1'b0;
         end
      endcase
   end

   // State, hit counter and registered outputs with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r   <= IDLE;
         hitCnt_r  <= 3'd0;
         found_r   <= 3'd0;
         start_r   <= 1'b0;
         weCsd_r   <= 1'b0;
         reCsd_r   <= 1'b0;
         weK_r     <= 1'b0;
         reK_r     <= 1'b0;
         load_r    <= 1'b0;
         loadCnt_r <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         state_r   <= nextState_s;
         hitCnt_r  <= hitNext_s;
         found_r   <= foundD_s;
         start_r   <= startD_s;
         weCsd_r   <= weCsdD_s;
         reCsd_r   <= reCsdD_s;
         weK_r     <= weKD_s;
         reK_r     <= reKD_s;
         load_r    <= loadD_s;
         loadCnt_r <= loadCntD_s;
         busy_r    <= busyD_s;
         done_r    <= doneD_s;
      end
   end

   assign bus.start   = start_r;
   assign bus.weCsd   = weCsd_r;
   assign bus.reCsd   = reCsd_r;
   assign bus.weK     = weK_r;
   assign bus.reK     = reK_r;
   assign bus.Load    = load_r;
   assign bus.loadCnt = loadCnt_r;
   assign bus.busy    = busy_r;
   assign bus.done    = done_r;
   assign bus.found   = found_r;
   assign bus.enCnt   = enCnt_s;
   assign bus.enable  = enable_s;

endmodule

// File: tb/tb_csd_scan_ctrl.sv
// Directed bench for csd_scan_ctrl with a behavioural CSD/K datapath model and
// a scoreboard of expected K-memory writes.
module tb_csd_scan_ctrl;

   logic clk;
   logic reset;
   csd_scan_ctrl_if bus ();

   csd_scan_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Datapath model: counters, CSD memory, K memory and regK0..3
   logic [3:0] iCnt;
   logic [2:0] cnti;
   logic [7:0] csdMem [16];
   logic [7:0] csdData;
   logic [7:0] kMem [4];
   logic [7:0] kData;
   logic [7:0] regK [4];
   logic [3:0] hostAddr;
   logic [7:0] hostData;
   logic [3:0] csdAddr;
   logic [2:0] cntiM1;

   assign csdAddr  = bus.start ? iCnt : hostAddr;
   assign cntiM1   = cnti - 3'd1;
   assign bus.Zi   = (iCnt < 4'd15);
   assign bus.Zcsd = (csdData == 8'h01);
   assign bus.Zcnt = (cnti == 3'd4);

   always @(posedge clk) begin
      if (!reset) begin
         iCnt    <= 4'd0;
         cnti    <= 3'd0;
         csdData <= 8'd0;
         kData   <= 8'd0;
         for (int k = 0; k < 4; k++) begin
            kMem[k] <= 8'd0;
            regK[k] <= 8'd0;
         end
      end else begin
         if (bus.Load) iCnt <= 4'd0;
         else if (bus.enable) iCnt <= iCnt + 4'd1;
         if (bus.loadCnt) cnti <= 3'd0;
         else if (bus.enCnt) cnti <= cnti + 3'd1;
         if (bus.weCsd) csdMem[csdAddr] <= hostData;
         if (bus.reCsd) csdData <= csdMem[csdAddr];
         if (bus.weK) kMem[cntiM1[1:0]] <= {4'h0, iCnt};
         if (bus.reK) kData <= kMem[cnti[1:0]];
         for (int n = 0; n < 4; n++) begin
            if (cnti == 3'(n + 1)) regK[n] <= kData;
         end
      end
   end

   int nVec = 0;
   int nErr = 0;
   int sbQ[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nVec++;
      assert (obs === exp) else begin
         nErr++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [13:0] outVec();
      return {bus.start, bus.weCsd, bus.reCsd, bus.weK, bus.reK, bus.Load,
              bus.enable, bus.loadCnt, bus.enCnt, bus.busy, bus.done, bus.found};
   endfunction

   task automatic doReset();
      @(negedge clk) reset = 1'b0;
      @(negedge clk) reset = 1'b1;
      sbQ.delete();
   endtask

   // Write all 16 CSD entries through the host path; hostWe reaches weCsd one cycle later
   task automatic loadCsd(input logic [15:0] mask, input bit fill);
      logic [7:0] a8;
      for (int a = 0; a < 16; a++) begin
         @(negedge clk);
         chk("weCsdIdleLow", 32'(bus.weCsd), 32'd0);
         a8       = 8'(a);
         hostAddr = a8[3:0];
         hostData = mask[a] ? 8'h01 : (fill ? (8'h81 ^ a8) : 8'h00);
         bus.hostWe = 1'b1;
         @(negedge clk);
         chk("weCsdFollow", 32'(bus.weCsd), 32'd1);
         bus.hostWe = 1'b0;
      end
      @(negedge clk);
   endtask

   // Step from cycle firstCyc (already at its negedge) until done, scoring weK writes
   task automatic waitDone(input string name, input int firstCyc, input bit toggleWe,
                           output int doneCyc, output int readMax, output int loads,
                           output int weLeak);
      int popV;
      doneCyc = 0; readMax = -1; loads = 0; weLeak = 0;
      for (int c = firstCyc; c <= 200 && doneCyc == 0; c++) begin
         if (c > firstCyc) @(negedge clk);
         if (toggleWe) bus.hostWe = (c % 2 == 1);
         if (c == 1) chk({name, "_busyRise"}, 32'(bus.busy), 32'd1);
         if (bus.Load) loads++;
         if (bus.busy && bus.weCsd) weLeak++;
         if (bus.reCsd && int'(iCnt) > readMax) readMax = int'(iCnt);
         if (bus.weK) begin
            popV = (sbQ.size() > 0) ? sbQ.pop_front() : 99;
            chk({name, "_weK_i"}, 32'(iCnt), popV);
         end
         if (bus.done) doneCyc = c;
      end
      bus.hostWe = 1'b0;
      chk({name, "_doneSeen"}, 32'(doneCyc != 0), 32'd1);
   endtask

   task automatic runTest(input string name, input logic [15:0] mask, input int expLat,
                          input bit holdGo, input bit toggleWe);
      int hits[$];
      int nHit, expRead, doneCyc, readMax, loads, weLeak;
      nHit = 0;
      for (int a = 0; a < 16; a++) begin
         if (mask[a] && nHit < 4) begin
            hits.push_back(a);
            sbQ.push_back(a);
            nHit++;
         end
      end
      expRead = (nHit == 4) ? hits[3] : 15;

      @(negedge clk) bus.go = 1'b1;
      @(negedge clk) if (!holdGo) bus.go = 1'b0;
      waitDone(name, 1, toggleWe, doneCyc, readMax, loads, weLeak);
      if (expLat > 0) chk({name, "_latency"}, 32'(doneCyc), 32'(expLat));
      chk({name, "_found"}, 32'(bus.found), 32'(nHit));
      for (int n = 0; n < 4; n++) begin
         chk({name, "_regK"}, 32'(regK[n]), (n < nHit) ? 32'(hits[n]) : 32'd0);
      end
      chk({name, "_lastRead"}, 32'(readMax), 32'(expRead));
      chk({name, "_sbEmpty"}, 32'(sbQ.size()), 32'd0);
      chk({name, "_oneRun"}, 32'(loads), 32'd1);
      chk({name, "_weCsdBusy"}, 32'(weLeak), 32'd0);
      @(negedge clk);
      chk({name, "_busyFall"}, 32'(bus.busy), 32'd0);
      chk({name, "_donePulse"}, 32'(bus.done), 32'd0);

      if (holdGo) begin
         for (int n = 0; n < nHit; n++) sbQ.push_back(hits[n]);
         @(negedge clk);
         bus.go = 1'b0;
         waitDone({name, "Run2"}, 1, toggleWe, doneCyc, readMax, loads, weLeak);
         chk({name, "Run2_latency"}, 32'(doneCyc), 32'(expLat));
         chk({name, "Run2_found"}, 32'(bus.found), 32'(nHit));
         chk({name, "Run2_sbEmpty"}, 32'(sbQ.size()), 32'd0);
         chk({name, "Run2_weCsdBusy"}, 32'(weLeak), 32'd0);
         @(negedge clk);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      reset      = 1'b0;
      bus.go     = 1'b0;
      bus.hostWe = 1'b0;
      hostAddr   = 4'd0;
      hostData   = 8'd0;
      repeat (3) @(negedge clk);
      chk("resetOutputs", 32'(outVec()), 32'd0);
      reset = 1'b1;

      // No hits anywhere
      loadCsd(16'h0000, 1'b0);
      runTest("noHits", 16'h0000, 56, 1'b0, 1'b0);

      // Four hits, scan stops at address 12
      doReset();
      loadCsd(16'h1224, 1'b1);
      runTest("hits2_5_9_12", 16'h1224, -1, 1'b0, 1'b0);

      // Three hits including the last address
      doReset();
      loadCsd(16'h8081, 1'b1);
      runTest("hits0_7_15", 16'h8081, 59, 1'b0, 1'b0);

      // Fifth 8'h01 at address 8 must never be read
      doReset();
      loadCsd(16'h015A, 1'b1);
      runTest("fiveOnes", 16'h015A, -1, 1'b0, 1'b0);

      // Reset pulse while reading address 6
      doReset();
      loadCsd(16'h0401, 1'b1);
      @(negedge clk) bus.go = 1'b1;
      @(negedge clk) bus.go = 1'b0;
      seen = 0;
      for (int c = 0; c < 100 && seen == 0; c++) begin
         if (bus.reCsd && iCnt == 4'd6) seen = 1;
         else @(negedge clk);
      end
      chk("midReset_reachI6", 32'(seen), 32'd1);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      chk("midReset_outputs", 32'(outVec()), 32'd0);
      seen = 0;
      for (int c = 0; c < 70; c++) begin
         @(negedge clk);
         if (bus.done) seen = 1;
      end
      chk("midReset_noDone", 32'(seen), 32'd0);
      runTest("afterReset", 16'h0401, 58, 1'b0, 1'b0);

      // go held through the run with hostWe toggling; harmless write data in IDLE
      hostAddr = 4'd15;
      hostData = 8'h00;
      runTest("goHeld", 16'h0401, 58, 1'b1, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

endmodule
